// File: rtl/clause_pkg.sv
// Shared encodings and types for the clause evaluation slice.
package clause_pkg;

    localparam int DEF_NUM_VARS  = 8;
    localparam int DEF_WIDTH_LVL = 16;

    localparam logic [1:0] LIT_ABSENT   = 2'b00;
    localparam logic [1:0] LIT_POS      = 2'b01;
    localparam logic [1:0] LIT_NEG      = 2'b10;

    localparam logic [1:0] VAL_FREE     = 2'b00;
    localparam logic [1:0] VAL_CONFLICT = 2'b11;

    typedef struct packed {
        logic [1:0] val;
        logic       imp;
    } var_value_t;

endpackage

// File: rtl/clause_lit_cell.sv
// One literal slot: classifies the variable against the stored literal code
// and produces this slot's local value drive.
module clause_lit_cell
    import clause_pkg::*;
(
    input  logic [1:0] i_code,
    input  logic [1:0] i_val,
    input  logic       i_imp_drv,
    input  logic       i_conflict_drv,
    output logic       o_is_lit,
    output logic       o_sat,
    output logic       o_free,
    output logic       o_assigned,
    output var_value_t o_drive
);

    always_comb begin
        o_is_lit   = (i_code != LIT_ABSENT);
        // A conflict-marked variable never satisfies a literal.
        o_sat      = o_is_lit && (i_val == i_code) && (i_val != VAL_CONFLICT);
        o_free     = o_is_lit && (i_val == VAL_FREE);
        o_assigned = o_is_lit && (i_val != VAL_FREE);
        o_drive    = '0;
        if (i_imp_drv && o_free) begin
            o_drive = '{val: i_code, imp: 1'b1};
        end else if (i_conflict_drv && o_is_lit) begin
            o_drive = '{val: VAL_CONFLICT, imp: 1'b0};
        end
    end

endmodule

// File: rtl/clause1.sv
// Clause evaluator: stores one clause, reports satisfaction, implications and conflicts.
// Level propagation is enabled with macro CLAUSE1_LVL_EN; otherwise levels pass through.
module clause1
    import clause_pkg::*;
#(
    parameter int NUM_VARS  = DEF_NUM_VARS,
    parameter int WIDTH_LVL = DEF_WIDTH_LVL
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_VARS*3-1:0]         var_value_i,
    input  logic [NUM_VARS*3-1:0]         var_value_down_i,
    output logic [NUM_VARS*3-1:0]         var_value_down_o,
    input  logic [NUM_VARS*WIDTH_LVL-1:0] var_lvl_i,
    input  logic [NUM_VARS*WIDTH_LVL-1:0] var_lvl_down_i,
    output logic [NUM_VARS*WIDTH_LVL-1:0] var_lvl_down_o,
    input  logic                          wr_i,
    input  logic [NUM_VARS*2-1:0]         clause_i,
    output logic [NUM_VARS*2-1:0]         clause_o,
    input  logic [4:0]                    clause_len_i,
    output logic [4:0]                    clause_len_o,
    input  logic                          apply_bkt_i,
    output logic                          all_c_sat_o
);

    localparam int CNT_W = $clog2(NUM_VARS + 1);

    logic [NUM_VARS*2-1:0] r_clause;
    logic [4:0]            r_clause_len;

    logic [NUM_VARS-1:0]   w_is_lit;
    logic [NUM_VARS-1:0]   w_sat;
    logic [NUM_VARS-1:0]   w_free;
    logic [NUM_VARS-1:0]   w_assigned;
    var_value_t            w_drive [NUM_VARS];

    logic [CNT_W-1:0]      freelitcnt;
    logic                  imp_drv;
    logic                  conflict_c_drv;
    logic [WIDTH_LVL-1:0]  cmax_lvl_from_lits;
    logic                  w_unused_imp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clause     <= '0;
            r_clause_len <= '0;
        end else if (wr_i) begin
            r_clause     <= clause_i;
            r_clause_len <= clause_len_i;
        end
    end

    assign clause_o     = r_clause;
    assign clause_len_o = r_clause_len;

    for (genvar i = 0; i < NUM_VARS; i++) begin : g_cell
        clause_lit_cell u_cell (
            .i_code         (r_clause[2*i +: 2]),
            .i_val          (var_value_i[3*i+1 +: 2]),
            .i_imp_drv      (imp_drv),
            .i_conflict_drv (conflict_c_drv),
            .o_is_lit       (w_is_lit[i]),
            .o_sat          (w_sat[i]),
            .o_free         (w_free[i]),
            .o_assigned     (w_assigned[i]),
            .o_drive        (w_drive[i])
        );
    end

    always_comb begin
        freelitcnt   = '0;
        w_unused_imp = 1'b0;
        for (int i = 0; i < NUM_VARS; i++) begin
            freelitcnt   = freelitcnt + CNT_W'(w_free[i]);
            w_unused_imp = w_unused_imp ^ var_value_i[3*i];
        end
    end

    // An empty clause has no literals, so it is never satisfied and never drives.
    assign all_c_sat_o    = |w_sat;
    assign imp_drv        = !all_c_sat_o && (freelitcnt == CNT_W'(1));
    assign conflict_c_drv = !all_c_sat_o && (freelitcnt == '0) && (|w_is_lit);

    always_comb begin
        for (int i = 0; i < NUM_VARS; i++) begin
            var_value_down_o[3*i +: 3] = var_value_down_i[3*i +: 3]
                                       | (apply_bkt_i ? 3'b000 : w_drive[i]);
        end
    end

`ifdef CLAUSE1_LVL_EN
    always_comb begin
        cmax_lvl_from_lits = '0;
        for (int i = 0; i < NUM_VARS; i++) begin
            if (w_assigned[i] && (var_lvl_i[WIDTH_LVL*i +: WIDTH_LVL] > cmax_lvl_from_lits)) begin
                cmax_lvl_from_lits = var_lvl_i[WIDTH_LVL*i +: WIDTH_LVL];
            end
        end
    end

    // The implied slot inherits the deepest level among the assigned literals.
    always_comb begin
        var_lvl_down_o = var_lvl_down_i;
        for (int i = 0; i < NUM_VARS; i++) begin
            if (imp_drv && w_free[i] && !apply_bkt_i) begin
                var_lvl_down_o[WIDTH_LVL*i +: WIDTH_LVL] = cmax_lvl_from_lits;
            end
        end
    end
`else
    logic w_unused_lvl;

    assign cmax_lvl_from_lits = '0;
    assign var_lvl_down_o     = var_lvl_down_i;
    assign w_unused_lvl       = (^var_lvl_i) ^ (^w_assigned);
`endif

endmodule

// File: tb/tb_clause1.sv
module tb_clause1;

   localparam int NV = 8;
   localparam int WL = 16;
`ifdef CLAUSE1_LVL_EN
   localparam bit LVL_EN = 1'b1;
`else
   localparam bit LVL_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic [NV*3-1:0]   var_value_i;
   logic [NV*3-1:0]   var_value_down_i;
   logic [NV*3-1:0]   var_value_down_o;
   logic [NV*WL-1:0]  var_lvl_i;
   logic [NV*WL-1:0]  var_lvl_down_i;
   logic [NV*WL-1:0]  var_lvl_down_o;
   logic              wr_i;
   logic [NV*2-1:0]   clause_i;
   logic [NV*2-1:0]   clause_o;
   logic [4:0]        clause_len_i;
   logic [4:0]        clause_len_o;
   logic              apply_bkt_i;
   logic              all_c_sat_o;

   clause1 #(.NUM_VARS(NV), .WIDTH_LVL(WL)) dut (
      .clk              (clk),
      .rst              (rst),
      .var_value_i      (var_value_i),
      .var_value_down_i (var_value_down_i),
      .var_value_down_o (var_value_down_o),
      .var_lvl_i        (var_lvl_i),
      .var_lvl_down_i   (var_lvl_down_i),
      .var_lvl_down_o   (var_lvl_down_o),
      .wr_i             (wr_i),
      .clause_i         (clause_i),
      .clause_o         (clause_o),
      .clause_len_i     (clause_len_i),
      .clause_len_o     (clause_len_o),
      .apply_bkt_i      (apply_bkt_i),
      .all_c_sat_o      (all_c_sat_o)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NV*3-1:0] vals3(input logic [2:0] v1, input logic [2:0] v3,
                                             input logic [2:0] v5);
      logic [NV*3-1:0] r;
      r          = '0;
      r[3 +: 3]  = v1;
      r[9 +: 3]  = v3;
      r[15 +: 3] = v5;
      return r;
   endfunction

   logic [NV*WL-1:0] exp_lvl;

   initial begin
      rst              = 1'b1;
      wr_i             = 1'b0;
      clause_i         = '0;
      clause_len_i     = '0;
      apply_bkt_i      = 1'b0;
      var_value_i      = '0;
      var_value_down_i = '0;
      for (int i = 0; i < NV; i++) begin
         var_lvl_i[i*WL +: WL]      = WL'(i + 1);
         var_lvl_down_i[i*WL +: WL] = 16'h0A00 + WL'(i);
      end

      #12;
      chk("rst_clause", clause_o, 16'h0000);
      chk("rst_len", clause_len_o, 5'd0);
      chk("rst_sat", all_c_sat_o, 1'b0);
      chk("rst_down", var_value_down_o, 24'h000000);

      rst = 1'b0;
      #1;
      chk("empty_sat", all_c_sat_o, 1'b0);
      chk("empty_conf", dut.conflict_c_drv, 1'b0);
      chk("empty_down", var_value_down_o, 24'h000000);
      chk("empty_lvl", var_lvl_down_o, var_lvl_down_i);

      clause_i     = 16'h0884;
      clause_len_i = 5'd3;
      wr_i         = 1'b1;
      @(posedge clk);
      #1;
      wr_i = 1'b0;
      chk("wr_clause", clause_o, 16'h0884);
      chk("wr_len", clause_len_o, 5'd3);

      var_value_i = vals3(3'b010, 3'b100, 3'b100);
      #1;
      chk("sat_flag", all_c_sat_o, 1'b1);
      chk("sat_cmax", dut.cmax_lvl_from_lits, LVL_EN ? 16'd6 : 16'd0);
      chk("sat_down", var_value_down_o, 24'h000000);
      chk("sat_lvl", var_lvl_down_o, var_lvl_down_i);

      var_value_i = '0;
      #1;
      chk("free_cnt", dut.freelitcnt, 4'd3);
      chk("free_cmax", dut.cmax_lvl_from_lits, 16'd0);
      chk("free_sat", all_c_sat_o, 1'b0);
      chk("free_imp", dut.imp_drv, 1'b0);
      chk("free_conf", dut.conflict_c_drv, 1'b0);
      chk("free_down", var_value_down_o, 24'h000000);

      var_value_i = vals3(3'b100, 3'b000, 3'b010);
      #1;
      exp_lvl = var_lvl_down_i;
      exp_lvl[3*WL +: WL] = LVL_EN ? 16'd6 : var_lvl_down_i[3*WL +: WL];
      chk("imp_cnt", dut.freelitcnt, 4'd1);
      chk("imp_flag", dut.imp_drv, 1'b1);
      chk("imp_down", var_value_down_o, 24'h000A00);
      chk("imp_lvl", var_lvl_down_o, exp_lvl);

      var_value_down_i = 24'h000001;
      #1;
      chk("imp_cascade", var_value_down_o, 24'h000A01);
      var_value_down_i = '0;

      var_value_i = vals3(3'b100, 3'b111, 3'b010);
      #1;
      chk("conf_flag", dut.conflict_c_drv, 1'b1);
      chk("conf_imp", dut.imp_drv, 1'b0);
      chk("conf_down", var_value_down_o, 24'h030C30);
      chk("conf_lvl", var_lvl_down_o, var_lvl_down_i);

      var_value_i = vals3(3'b100, 3'b000, 3'b010);
      apply_bkt_i = 1'b1;
      #1;
      chk("bkt_down", var_value_down_o, 24'h000000);
      chk("bkt_lvl", var_lvl_down_o, var_lvl_down_i);
      apply_bkt_i = 1'b0;

      var_value_i = vals3(3'b010, 3'b100, 3'b100);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("arst_clause", clause_o, 16'h0000);
      chk("arst_len", clause_len_o, 5'd0);
      chk("arst_sat", all_c_sat_o, 1'b0);

      clause_i     = 16'h0884;
      clause_len_i = 5'd3;
      wr_i         = 1'b1;
      @(posedge clk);
      #1;
      chk("arst_wr_clause", clause_o, 16'h0000);
      chk("arst_wr_len", clause_len_o, 5'd0);
      wr_i = 1'b0;
      rst  = 1'b0;
      @(posedge clk);
      #1;
      chk("post_rst_clause", clause_o, 16'h0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/clause1.md
CLAUSE1 -- requirements
Module: clause1

Interface
REQ-001 The parameter NUM_VARS SHALL default to 8 and set the number of variable slots in the clause.
REQ-002 The parameter WIDTH_LVL SHALL default to 16 and set the bit width of each decision-level field.
REQ-003 Port clk SHALL be an input of 1 bit and be the single clock.
REQ-004 Port rst SHALL be an input of 1 bit and be an asynchronous, active-high reset.
REQ-005 Port var_value_i SHALL be an input of NUM_VARS*3 bits: current value of each variable, slot i at bits [3i+2:3i].
REQ-006 Port var_value_down_i SHALL be an input of NUM_VARS*3 bits: drives cascaded from the previous clause.
REQ-007 Port var_value_down_o SHALL be an output of NUM_VARS*3 bits: cascaded drives including this clause's.
REQ-008 Port var_lvl_i SHALL be an input of NUM_VARS*WIDTH_LVL bits: decision level of each variable.
REQ-009 Port var_lvl_down_i SHALL be an input of NUM_VARS*WIDTH_LVL bits: cascaded levels in.
REQ-010 Port var_lvl_down_o SHALL be an output of NUM_VARS*WIDTH_LVL bits: cascaded levels out.
REQ-011 Port wr_i SHALL be an input of 1 bit that strobes a clause write.
REQ-012 Port clause_i SHALL be an input of NUM_VARS*2 bits: literal code per slot to be written.
REQ-013 Port clause_o SHALL be an output of NUM_VARS*2 bits: the stored clause.
REQ-014 Ports clause_len_i and clause_len_o SHALL be 5 bits each: input length to write, and stored length out.
REQ-015 Port apply_bkt_i SHALL be an input of 1 bit; while high it suppresses local drives during backtrack.
REQ-016 Port all_c_sat_o SHALL be an output of 1 bit that is high when the clause is satisfied.

Function
REQ-017 Encodings:
- Literal code: 00 absent, 01 or 10 = value the variable must take.
- Variable value: {val[1:0], imp}; val 00 = free, 01 or 10 = assigned, 11 = conflict marker.
REQ-018 On each clk rising edge with wr_i=1, the block SHALL store clause_i and clause_len_i; these appear on clause_o and clause_len_o the next cycle.
REQ-019 Literal status per slot with code != 00: satisfied if val == code; free if val == 00; otherwise false. val 11 counts as false.
REQ-020 The following internal combinational signals SHALL exist with these names:
- freelitcnt: count of free literals, width $clog2(NUM_VARS+1).
- all_c_sat_o: 1 when any literal is satisfied.
- imp_drv = !all_c_sat_o && freelitcnt==1.
- conflict_c_drv = !all_c_sat_o && freelitcnt==0 && clause non-empty.
- cmax_lvl_from_lits: maximum var_lvl over literals whose val != 00, or 0 if there are none.
REQ-021 All status and drive outputs SHALL be combinational from var_value_i, var_lvl_i and the stored clause, with zero latency.
REQ-022 Local value drive per slot:
- imp_drv: the free literal's slot gets {code,1}.
- conflict_c_drv: every literal slot gets {11,0}.
- Otherwise 000.
REQ-023 var_value_down_o SHALL equal var_value_down_i OR the local drive; the local drive is forced to 0 while apply_bkt_i=1.
REQ-024 var_lvl_down_o SHALL carry cmax_lvl_from_lits in the implied slot when a local implication drives; every other slot passes var_lvl_down_i.
REQ-025 An empty stored clause SHALL produce no drives and all_c_sat_o=0.

Reset
REQ-026 While rst=1, the stored clause and clause_len SHALL clear to 0, so clause_o=0, clause_len_o=0 and all drives are 0; reset takes effect immediately, even mid-write.

Configuration
REQ-027 With macro CLAUSE1_LVL_EN defined, the level logic SHALL behave as in REQ-020 and REQ-024.
REQ-028 Without CLAUSE1_LVL_EN, cmax_lvl_from_lits SHALL be 0 and var_lvl_down_o SHALL equal var_lvl_down_i.

Structure
REQ-029 A shared package clause_pkg SHALL hold:
- literal-code and value-code constants;
- the per-slot value struct typedef;
- default NUM_VARS and WIDTH_LVL.
REQ-030 One sub-module, clause_lit_cell, SHALL be instantiated NUM_VARS times; it classifies each slot and produces that slot's drive.

Verification
Common setup: clause written with codes slot1=01, slot3=10, slot5=10 and var_lvl slot i = i+1.
REQ-031 Set values slot1=01, slot3=10, slot5=10 -> all_c_sat_o=1, cmax_lvl_from_lits=6.
REQ-032 Set all values 000 -> freelitcnt=3, cmax_lvl_from_lits=0, no drives.
REQ-033 Set slot1=10, slot5=01, slot3 free -> freelitcnt=1, imp_drv=1, slot3 out=3'b101, slot3 level out=6.
REQ-034 Then set slot3=3'b111 -> conflict_c_drv=1; slots 1, 3 and 5 out=3'b110.
REQ-035 Repeat the REQ-033 stimulus with apply_bkt_i=1 and var_value_down_i=0 -> var_value_down_o=0.
REQ-036 Assert rst mid-operation -> clause_o=0, clause_len_o=0, all_c_sat_o=0.
